// File: rtl/ecg_sample_sched.sv
// ecg_sample_sched: paces alg_core sample requests against the sample FIFO.
// Pops the FIFO at most once per sample tick, converts offset-binary words to
// signed samples, numbers each delivered sample, and flags underruns/timeouts.
// Build option: define ECG_SCHED_RATE_LIMIT_EN to include the CLK_DIV sample-rate
// divider; without it every request is served as soon as the FIFO allows.
module ecg_sample_sched #(
    parameter int DATA_WIDTH  = 11,
    parameter int CTR_WIDTH   = 22,
    parameter int DATA_OFFSET = 1024,
    parameter int CLK_DIV     = 277778,
    parameter int TIMEOUT     = 8
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         ce,
    input  logic                         fifo_empty,
    output logic                         fifo_pop,
    input  logic [DATA_WIDTH-1:0]        fifo_rdata,
    input  logic                         fifo_rdata_valid,
    input  logic                         core_data_req,
    output logic                         core_data_valid,
    output logic signed [DATA_WIDTH-1:0] core_sample,
    output logic [CTR_WIDTH-1:0]         sample_num,
    output logic                         underrun,
    output logic [15:0]                  underrun_cnt,
    output logic                         err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_POP,
        S_WAIT_DATA
    } state_t;

    localparam int                    TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] OFFSET_W = DATA_WIDTH'(DATA_OFFSET);

    state_t               state;
    logic [TO_W-1:0]      to_cnt;
    logic [CTR_WIDTH-1:0] count;
    logic                 in_underrun;
    logic                 valid_q;
    logic                 tick_pend;
    logic                 blocked;

`ifdef ECG_SCHED_RATE_LIMIT_EN
    localparam int              DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             consume;

    assign tick    = ce && (div_cnt == DIV_LAST);
    assign consume = ce && (state == S_WAIT_TICK) && tick_pend;

    // Free-running sample-period divider, frozen while ce is low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt <= '0;
        end else if (ce) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // Single-entry tick store; a tick landing on the consume cycle survives it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_pend <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register
            // samples pre-edge values regardless of block evaluation order.
            tick_pend <= tick | (tick_pend & ~consume);
        end
    end
`else
    localparam int unused_clk_div = CLK_DIV;
    assign tick_pend = 1'b1;
`endif

    // Strobes are gated by ce so a frozen scheduler never talks to its neighbours.
    assign blocked         = ce && (state == S_POP) && fifo_empty;
    assign fifo_pop        = ce && (state == S_POP) && !fifo_empty;
    assign underrun        = blocked && !in_underrun;
    assign core_data_valid = ce && valid_q;

    // Request/pop/deliver sequencer with underrun and timeout bookkeeping.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            count        <= '0;
            in_underrun  <= 1'b0;
            valid_q      <= 1'b0;
            core_sample  <= '0;
            sample_num   <= '0;
            underrun_cnt <= '0;
            err_timeout  <= 1'b0;
        end else if (ce) begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (core_data_req) state <= S_WAIT_TICK;
                end
                S_WAIT_TICK: begin
                    if (tick_pend) state <= S_POP;
                end
                S_POP: begin
                    if (!fifo_empty) begin
                        state       <= S_WAIT_DATA;
                        to_cnt      <= '0;
                        in_underrun <= 1'b0;
                    end else begin
                        // Count each blocked episode once, not every retry cycle.
                        in_underrun <= 1'b1;
                        if (!in_underrun && underrun_cnt != 16'hFFFF)
                            underrun_cnt <= underrun_cnt + 16'd1;
                    end
                end
                S_WAIT_DATA: begin
                    if (fifo_rdata_valid) begin
                        core_sample <= $signed(fifo_rdata - OFFSET_W);
                        sample_num  <= count;
                        count       <= count + 1'b1;
                        valid_q     <= 1'b1;
                        state       <= S_IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_POP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecg_sample_sched.sv
// Self-checking bench for ecg_sample_sched: FIFO model with 1-cycle read
// latency, directed and random words, and timing derived from the sample rules.
module tb_ecg_sample_sched;

    localparam int DW      = 11;
    localparam int CW      = 22;
    localparam int OFFSET  = 1024;
    localparam int CLK_DIV = 10;
    localparam int TIMEOUT = 8;
`ifdef ECG_SCHED_RATE_LIMIT_EN
    localparam int PERIOD = CLK_DIV;
`else
    localparam int PERIOD = 4;
`endif

    logic                 clk;
    logic                 nrst;
    logic                 ce;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DW-1:0]        fifo_rdata;
    logic                 fifo_rdata_valid;
    logic                 core_data_req;
    logic                 core_data_valid;
    logic signed [DW-1:0] core_sample;
    logic [CW-1:0]        sample_num;
    logic                 underrun;
    logic [15:0]          underrun_cnt;
    logic                 err_timeout;

    ecg_sample_sched #(
        .DATA_WIDTH (DW),
        .CTR_WIDTH  (CW),
        .DATA_OFFSET(OFFSET),
        .CLK_DIV    (CLK_DIV),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .ce              (ce),
        .fifo_empty      (fifo_empty),
        .fifo_pop        (fifo_pop),
        .fifo_rdata      (fifo_rdata),
        .fifo_rdata_valid(fifo_rdata_valid),
        .core_data_req   (core_data_req),
        .core_data_valid (core_data_valid),
        .core_sample     (core_sample),
        .sample_num      (sample_num),
        .underrun        (underrun),
        .underrun_cnt    (underrun_cnt),
        .err_timeout     (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int sample;
        int num;
    } strobe_t;

    int            checks;
    int            errors;
    int            cyc;
    int            underrun_pulses;
    int            pop_count;
    logic          pop_prev;
    logic          hold_valid;
    logic [DW-1:0] fifo_q[$];
    strobe_t       strobes[$];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: FIFO answers last cycle's pop, then outputs are sampled.
    task automatic step();
        strobe_t s;
        @(posedge clk);
        #1;
        cyc++;
        if (nrst && pop_prev && !hold_valid && fifo_q.size() > 0) begin
            fifo_rdata       = fifo_q.pop_front();
            fifo_rdata_valid = 1'b1;
        end else begin
            fifo_rdata_valid = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
        pop_prev = fifo_pop;
        if (fifo_pop) pop_count++;
        if (underrun) underrun_pulses++;
        if (core_data_valid) begin
            s.cyc    = cyc;
            s.sample = int'($signed(core_sample));
            s.num    = int'(sample_num);
            strobes.push_back(s);
        end
        if (fifo_q.size() == 0) core_data_req = 1'b0;
    endtask

    task automatic do_reset();
        nrst             = 1'b0;
        ce               = 1'b1;
        core_data_req    = 1'b0;
        fifo_rdata_valid = 1'b0;
        fifo_rdata       = '0;
        fifo_empty       = 1'b1;
        hold_valid       = 1'b0;
        pop_prev         = 1'b0;
        underrun_pulses  = 0;
        pop_count        = 0;
        fifo_q.delete();
        strobes.delete();
        step();
        step();
        nrst = 1'b1;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (strobes.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, strobes.size(), n);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_fifo_pop"},        fifo_pop,        0);
        check({pfx, "_core_data_valid"}, core_data_valid, 0);
        check({pfx, "_core_sample"},     core_sample,     0);
        check({pfx, "_sample_num"},      sample_num,      0);
        check({pfx, "_underrun"},        underrun,        0);
        check({pfx, "_underrun_cnt"},    underrun_cnt,    0);
        check({pfx, "_err_timeout"},     err_timeout,     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] words[$];
        logic [DW-1:0] w;
        int            k;
        int            p;
        int            found;

        checks = 0;
        errors = 0;
        cyc    = 0;

        // Reset values
        do_reset();
        check_all_zero("reset");

        // Conversion and rate: directed corner words then random words
        words.push_back(11'h400);
        words.push_back(11'h7FF);
        words.push_back(11'h000);
        words.push_back(11'h3FF);
        for (int i = 0; i < 8; i++) words.push_back(DW'($urandom_range(0, 2047)));
        foreach (words[i]) fifo_q.push_back(words[i]);
        step();
        core_data_req = 1'b1;
        wait_strobes(12, 12 * PERIOD + 40, "rate_count");
        for (int i = 0; i < strobes.size() && i < 12; i++) begin
            check($sformatf("conv_sample_%0d", i), strobes[i].sample, int'(words[i]) - OFFSET);
            check($sformatf("conv_num_%0d", i), strobes[i].num, i);
            if (i >= 2)
                check($sformatf("rate_gap_%0d", i), strobes[i].cyc - strobes[i-1].cyc, PERIOD);
        end
        repeat (3 * PERIOD) step();
        check("rate_no_extra_strobe", strobes.size(), 12);
        check("rate_no_underrun_cnt", underrun_cnt, 0);
        check("rate_no_underrun_pulse", underrun_pulses, 0);

        // Minimum latency with a stored tick
        do_reset();
        repeat (15) step();
        w = DW'($urandom_range(0, 2047));
        fifo_q.push_back(w);
        step();
        k = cyc;
        core_data_req = 1'b1;
        wait_strobes(1, 40, "lat_count");
        if (strobes.size() > 0) begin
            check("lat_cycles", strobes[0].cyc - k, 4);
            check("lat_sample", strobes[0].sample, int'(w) - OFFSET);
        end

        // ce held low for 20 cycles while waiting for the tick
        do_reset();
        repeat (15) step();
        fifo_q.push_back(w);
        step();
        k = cyc;
        core_data_req = 1'b1;
        step();
        ce = 1'b0;
        repeat (20) step();
        ce = 1'b1;
        wait_strobes(1, 40, "freeze_count");
        if (strobes.size() > 0) check("freeze_cycles", strobes[0].cyc - k, 24);
        check("freeze_pops", pop_count, 1);

        // Underrun: request against an empty FIFO
        do_reset();
        repeat (15) step();
        core_data_req = 1'b1;
        repeat (10) step();
        check("under_pulses", underrun_pulses, 1);
        check("under_cnt", underrun_cnt, 1);
        check("under_no_pop", pop_count, 0);
        fifo_q.push_back(11'h500);
        step();
        check("under_pop_next", pop_prev, 1);
        wait_strobes(1, 10, "under_count");
        if (strobes.size() > 0) begin
            check("under_sample", strobes[0].sample, 256);
            check("under_num", strobes[0].num, 0);
        end
        check("under_cnt_after", underrun_cnt, 1);

        // Read timeout: withhold valid after the pop
        w = DW'($urandom_range(0, 2047));
        fifo_q.push_back(w);
        hold_valid = 1'b1;
        step();
        core_data_req = 1'b1;
        found = 0;
        p = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (pop_prev) begin
                found = 1;
                p = cyc;
            end
        end
        check("to_pop_seen", found, 1);
        repeat (TIMEOUT) step();
        check("to_not_early", err_timeout, 0);
        step();
        check("to_err_set", err_timeout, 1);
        check("to_repop", pop_prev, 1);
        hold_valid = 1'b0;
        wait_strobes(2, 20, "to_count");
        if (strobes.size() > 1) begin
            check("to_cycles", strobes[1].cyc - p, TIMEOUT + 3);
            check("to_sample", strobes[1].sample, int'(w) - OFFSET);
            check("to_num", strobes[1].num, 1);
        end
        check("to_sticky", err_timeout, 1);

        // Asynchronous reset in the middle of a transfer
        fifo_q.push_back(11'h123);
        step();
        core_data_req = 1'b1;
        step();
        step();
        #1;
        nrst = 1'b0;
        #1;
        check_all_zero("async");
        do_reset();
        w = DW'($urandom_range(0, 2047));
        fifo_q.push_back(w);
        step();
        core_data_req = 1'b1;
        wait_strobes(1, 40, "post_reset_count");
        if (strobes.size() > 0) begin
            check("post_reset_num", strobes[0].num, 0);
            check("post_reset_sample", strobes[0].sample, int'(w) - OFFSET);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
